mips_processor: RTL and testbench
=================================

Name: mips_processor

Overview:
- Single-cycle 32-bit MIPS-subset processor: PC, instruction fetch unit, register file, ALU, data memory, control.
- Every instruction is fetched, executed and committed in exactly one clock cycle.
- Top-level block of the CPU; the verification bench preloads instruction memory by hierarchical path and checks register contents after N rising edges.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes (byte-addressed).
- DMEM_BYTES, 1024, data memory size in bytes (byte-addressed).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_out  output  32  current PC, for observation.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high.
- Internal structure (fixed instance paths, used by the bench):
  - IFU.imemory.storage.bytes: reg [7:0] array of IMEM_BYTES entries, preloadable with $readmemb, one byte per line.
  - registers.registers: reg [31:0] array [0:31].
- Reset:
  - PC = 0; all 32 registers = 0; pc_out = 0.
  - Memory contents are not altered by reset.
  - Reset asserted mid-run aborts the current instruction; no register or memory write occurs.
- Fetch:
  - Instruction = big-endian bytes at PC..PC+3 (byte at PC is bits 31:24).
  - Addresses beyond IMEM_BYTES read as 0, which decodes as a NOP (sll $0,$0,0).
- Timing: after k rising edges following reset release, exactly k instructions have retired; register and memory writes are visible immediately after the edge.
- Next PC:
  - Default PC+4.
  - beq taken: PC+4 + (sign-extended imm << 2).
  - j: {PC+4[31:28], target, 2'b00}.
- Register file:
  - Two combinational read ports, one write port written on the rising edge.
  - $0 always reads 0; writes to it are ignored.
- Immediate extension:
  - Sign-extend for addi, lw, sw, beq, slti.
  - Zero-extend for andi, ori.
  - lui writes {imm, 16'h0}.
- Supported instructions:
  - R-type (op 0): add, sub, and, or, slt, sll, srl, via funct field.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq.
  - J-type: j.
- Arithmetic:
  - 32-bit wrap-around; no overflow exceptions.
  - slt/slti compare as signed and write 1 or 0.
- Data memory:
  - Word access, big-endian, address = rs + sign-extended imm.
  - lw is combinational read; sw writes on the rising edge.
  - Addresses out of range: reads return 0, writes are ignored.
- Unsupported opcode or funct: no register write, no memory write, PC+4.

Test Plan:
- Immediate-logic program: addi $s0,$0,0xF0; addi $s1,$0,0x0F; addi $s2,$0,0xCC; addi $s3,$0,0xABCE; andi $t0,$s0,0xFF; andi $t1,$s2,0xF0; andi $t2,$s2,0x0F; andi $t3,$s2,0x04; andi $t4,$s3,0xABC2; 9 edges ->
  - s0=F0, s1=0F, s2=CC, s3=FFFFABCE
  - t0=F0, t1=C0, t2=0C, t3=04, t4=0000ABC2
- lui $t0,0x1234; ori $t0,$t0,0xABCD -> t0=1234ABCD; ori with 0x8000 zero-extends (no upper bits set).
- sw $t0,8($0); lw $t1,8($0) -> t1 equals t0; bytes at data address 8..11 are 12,34,AB,CD.
- beq $0,$0,+1 skips the next addi; j back to 0 loops; after reset, pc_out=0 regardless of clk.
- add/sub/slt: 0x7FFFFFFF+1 = 0x80000000 (no trap); slt(-1,1)=1; addi $0,$0,5 leaves $0=0.
- Reset pulse asserted between edges: PC and registers clear immediately without waiting for clk; execution restarts at address 0.

Source files
------------

// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle 32-bit MIPS-subset processor
//
// Purpose: fetches, executes and commits one instruction per rising clock
// edge. Supports add/sub/and/or/slt/sll/srl, addi/andi/ori/slti/lui,
// lw/sw, beq and j.
//
// Top-level ports (mips_processor):
//   clk     in   1   system clock, all state updates on the rising edge
//   reset   in   1   asynchronous active-high reset (PC and registers to 0)
//   pc_out  out  32  current program counter
//
// Hierarchy:
//   IFU.imemory.storage.bytes   instruction bytes, preloaded externally
//   registers.registers         32 x 32-bit general-purpose registers
//   dmemory.bytes               data bytes

// Byte-addressed big-endian word memory. A word access is in range only if
// all four bytes are inside the array. Out-of-range reads return 0 and
// out-of-range writes are dropped. The contents have no reset.
module byte_storage #(
    parameter int BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int AW = $clog2(BYTES);

    logic [7:0]    bytes [0:BYTES-1];
    logic          in_range;
    logic [AW-1:0] idx;

    assign in_range = (addr_i <= 32'(BYTES - 4));
    assign idx      = addr_i[AW-1:0];

    assign rdata_o = in_range ? {bytes[idx], bytes[idx + AW'(1)],
                                 bytes[idx + AW'(2)], bytes[idx + AW'(3)]}
                              : 32'h0;

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            bytes[idx]          <= wdata_i[31:24];
            bytes[idx + AW'(1)] <= wdata_i[23:16];
            bytes[idx + AW'(2)] <= wdata_i[15:8];
            bytes[idx + AW'(3)] <= wdata_i[7:0];
        end
    end
endmodule

// Read-only instruction memory. The write port of the backing store is tied
// off, so the contents come only from an external preload.
module imem #(
    parameter int BYTES = 1024
) (
    input  logic        clk_i,
    input  logic [31:0] addr_i,
    output logic [31:0] instr_o
);
    byte_storage #(.BYTES(BYTES)) storage (
        .clk_i   (clk_i),
        .we_i    (1'b0),
        .addr_i  (addr_i),
        .wdata_i (32'h0),
        .rdata_o (instr_o)
    );
endmodule

// Instruction fetch unit. Holds the PC, selects the next PC and fetches the
// current instruction.
//   jump_i takes priority over branch_taken_i. The two cannot both be set
//   for a legal instruction.
module ifu #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic [31:0] branch_off_i,
    input  logic [25:0] jump_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (jump_i) begin
            pc_d = {pc_plus4[31:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            pc_d = pc_plus4 + (branch_off_i << 2);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

    imem #(.BYTES(IMEM_BYTES)) imemory (
        .clk_i   (clk_i),
        .addr_i  (pc_q),
        .instr_o (instr_o)
    );
endmodule

// Register file with two combinational read ports and one write port. The
// write port is sampled on the rising edge. Register $0 is hardwired to
// zero on read, and writes to it are discarded.
module regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= 32'h0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            registers[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : registers[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : registers[ra2_i];
endmodule

module mips_processor #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] simm;
    logic [31:0] zimm;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;

    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        mem_we;
    logic        branch_taken;
    logic        jump;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];
    assign simm   = {{16{imm[15]}}, imm};
    assign zimm   = {16'h0, imm};

    // The data address is computed for every instruction. Only lw and sw
    // use it.
    assign dmem_addr = rs_val + simm;

    ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
        .clk_i          (clk),
        .rst_i          (reset),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .branch_off_i   (simm),
        .jump_target_i  (target),
        .pc_o           (pc),
        .instr_o        (instr)
    );

    regfile registers (
        .clk_i (clk),
        .rst_i (reset),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (reg_we),
        .wa_i  (reg_wa),
        .wd_i  (reg_wd)
    );

    // Memory has no reset of its own. Gating with reset prevents a store
    // from landing on an edge at which the CPU is held in reset.
    byte_storage #(.BYTES(DMEM_BYTES)) dmemory (
        .clk_i   (clk),
        .we_i    (mem_we && !reset),
        .addr_i  (dmem_addr),
        .wdata_i (rt_val),
        .rdata_o (dmem_rdata)
    );

    // Decode and execute. Any opcode or funct not listed here falls through
    // with no register or memory write, so such instructions act as NOPs.
    always_comb begin
        reg_we       = 1'b0;
        reg_wa       = rt;
        reg_wd       = 32'h0;
        mem_we       = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                reg_wa = rd;
                unique case (funct)
                    FN_ADD: begin reg_we = 1'b1; reg_wd = rs_val + rt_val; end
                    FN_SUB: begin reg_we = 1'b1; reg_wd = rs_val - rt_val; end
                    FN_AND: begin reg_we = 1'b1; reg_wd = rs_val & rt_val; end
                    FN_OR:  begin reg_we = 1'b1; reg_wd = rs_val | rt_val; end
                    FN_SLT: begin
                        reg_we = 1'b1;
                        reg_wd = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    end
                    FN_SLL: begin reg_we = 1'b1; reg_wd = rt_val << shamt; end
                    FN_SRL: begin reg_we = 1'b1; reg_wd = rt_val >> shamt; end
                    default: ;
                endcase
            end
            OP_ADDI: begin reg_we = 1'b1; reg_wd = rs_val + simm; end
            OP_ANDI: begin reg_we = 1'b1; reg_wd = rs_val & zimm; end
            OP_ORI:  begin reg_we = 1'b1; reg_wd = rs_val | zimm; end
            OP_SLTI: begin
                reg_we = 1'b1;
                reg_wd = {31'h0, $signed(rs_val) < $signed(simm)};
            end
            OP_LUI:  begin reg_we = 1'b1; reg_wd = {imm, 16'h0}; end
            OP_LW:   begin reg_we = 1'b1; reg_wd = dmem_rdata; end
            OP_SW:   mem_we = 1'b1;
            OP_BEQ:  branch_taken = (rs_val == rt_val);
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign pc_out = pc;
endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - scoreboard bench for mips_processor
module tb_mips_processor;
    logic        clk;
    logic        reset;
    logic [31:0] pc_out;

    mips_processor #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_out (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_REG = 0;
    localparam int K_PC  = 1;
    localparam int K_MEM = 2;

    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] T0 = 5'd8,  T1 = 5'd9,  T2 = 5'd10, T3 = 5'd11;
    localparam logic [4:0] T4 = 5'd12, T5 = 5'd13;
    localparam logic [4:0] S0 = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19;
    localparam logic [4:0] S4 = 5'd20, S5 = 5'd21, S6 = 5'd22, S7 = 5'd23;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic exp_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
        sb.push_back('{tag: tag, kind: K_REG, idx: int'(r), value: v});
    endtask

    task automatic exp_pc(input string tag, input logic [31:0] v);
        sb.push_back('{tag: tag, kind: K_PC, idx: 0, value: v});
    endtask

    task automatic exp_mem(input string tag, input int a, input logic [7:0] v);
        sb.push_back('{tag: tag, kind: K_MEM, idx: a, value: {24'h0, v}});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_REG:   obs = dut.registers.registers[e.idx];
                K_PC:    obs = pc_out;
                default: obs = {24'h0, dut.dmemory.bytes[e.idx]};
            endcase
            check_eq(e.tag, obs, e.value);
        end
    endtask

    // Holds reset, replaces instruction memory with prog, then releases
    // reset at a falling edge so the next rising edge retires instruction 0.
    task automatic start_program(input int hold_edges);
        reset = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 1024; a++) dut.IFU.imemory.storage.bytes[a] = 8'h00;
        for (int i = 0; i < prog.size(); i++) begin
            dut.IFU.imemory.storage.bytes[4*i]   = prog[i][31:24];
            dut.IFU.imemory.storage.bytes[4*i+1] = prog[i][23:16];
            dut.IFU.imemory.storage.bytes[4*i+2] = prog[i][15:8];
            dut.IFU.imemory.storage.bytes[4*i+3] = prog[i][7:0];
        end
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        check_eq("pc_held_in_reset", pc_out, 32'h0);
        reset = 1'b0;
    endtask

    task automatic run(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        #2;
        check_eq("reset_pc_async", pc_out, 32'h0);
        check_eq("reset_t0", dut.registers.registers[8], 32'h0);
        check_eq("reset_s7", dut.registers.registers[23], 32'h0);

        // Immediate-logic program
        prog = '{enc_i(6'h08, ZERO, S0, 16'h00F0), enc_i(6'h08, ZERO, S1, 16'h000F),
                 enc_i(6'h08, ZERO, S2, 16'h00CC), enc_i(6'h08, ZERO, S3, 16'hABCE),
                 enc_i(6'h0C, S0, T0, 16'h00FF),   enc_i(6'h0C, S2, T1, 16'h00F0),
                 enc_i(6'h0C, S2, T2, 16'h000F),   enc_i(6'h0C, S2, T3, 16'h0004),
                 enc_i(6'h0C, S3, T4, 16'hABC2)};
        start_program(1);
        exp_reg("imm_s0", S0, 32'h000000F0); exp_reg("imm_s1", S1, 32'h0000000F);
        exp_reg("imm_s2", S2, 32'h000000CC); exp_reg("imm_s3", S3, 32'hFFFFABCE);
        exp_reg("imm_t0", T0, 32'h000000F0); exp_reg("imm_t1", T1, 32'h000000C0);
        exp_reg("imm_t2", T2, 32'h0000000C); exp_reg("imm_t3", T3, 32'h00000004);
        exp_reg("imm_t4", T4, 32'h0000ABC2); exp_pc("imm_pc", 32'd36);
        run(9);
        drain();

        // lui/ori, zero-extension, store/load and out-of-range load
        prog = '{enc_i(6'h0F, ZERO, T0, 16'h1234), enc_i(6'h0D, T0, T0, 16'hABCD),
                 enc_i(6'h0D, ZERO, T2, 16'h8000), enc_i(6'h2B, ZERO, T0, 16'h0008),
                 enc_i(6'h23, ZERO, T1, 16'h0008), enc_i(6'h08, ZERO, T3, 16'h0007),
                 enc_i(6'h23, ZERO, T3, 16'h0400), enc_i(6'h08, ZERO, T4, 16'h000C),
                 enc_i(6'h23, T4, T5, 16'hFFFC)};
        start_program(0);
        exp_reg("lui_ori_t0", T0, 32'h1234ABCD); exp_reg("ori_zext_t2", T2, 32'h00008000);
        exp_reg("lw_t1", T1, 32'h1234ABCD);      exp_reg("lw_oob_t3", T3, 32'h0);
        exp_reg("lw_negoff_t5", T5, 32'h1234ABCD);
        exp_mem("dmem8", 8, 8'h12);  exp_mem("dmem9", 9, 8'h34);
        exp_mem("dmem10", 10, 8'hAB); exp_mem("dmem11", 11, 8'hCD);
        run(9);
        drain();

        // beq skip and j loop; reset held over several edges first
        prog = '{enc_i(6'h08, ZERO, T0, 16'h0001), enc_i(6'h04, ZERO, ZERO, 16'h0001),
                 enc_i(6'h08, ZERO, T0, 16'h0063), enc_i(6'h08, T1, T1, 16'h0001),
                 enc_j(26'h0)};
        start_program(3);
        exp_reg("beq_skip_t0", T0, 32'h1); exp_reg("loop_t1", T1, 32'h2);
        exp_pc("jump_pc", 32'h0);
        run(8);
        drain();

        // Arithmetic, signed compare, shifts, $0 and unsupported encodings
        prog = '{enc_i(6'h0F, ZERO, T0, 16'h7FFF), enc_i(6'h0D, T0, T0, 16'hFFFF),
                 enc_i(6'h08, ZERO, T1, 16'h0001), enc_r(T0, T1, T2, 5'd0, 6'h20),
                 enc_r(T1, T0, T3, 5'd0, 6'h22),   enc_i(6'h08, ZERO, T4, 16'hFFFF),
                 enc_r(T4, T1, S0, 5'd0, 6'h2A),   enc_r(T1, T4, S1, 5'd0, 6'h2A),
                 enc_i(6'h08, ZERO, ZERO, 16'h0005), enc_r(T0, T4, S2, 5'd0, 6'h24),
                 enc_r(T2, T1, S3, 5'd0, 6'h25),   enc_r(ZERO, T1, S4, 5'd4, 6'h00),
                 enc_r(ZERO, T2, S5, 5'd31, 6'h02), enc_i(6'h0A, T4, S6, 16'h0000),
                 enc_i(6'h3F, ZERO, S7, 16'h1234), enc_r(T1, T1, S7, 5'd0, 6'h3F)};
        start_program(0);
        exp_reg("add_wrap_t2", T2, 32'h80000000); exp_reg("sub_t3", T3, 32'h80000002);
        exp_reg("slt_neg_s0", S0, 32'h1);         exp_reg("slt_pos_s1", S1, 32'h0);
        exp_reg("and_s2", S2, 32'h7FFFFFFF);      exp_reg("or_s3", S3, 32'h80000001);
        exp_reg("sll_s4", S4, 32'h10);            exp_reg("srl_s5", S5, 32'h1);
        exp_reg("slti_s6", S6, 32'h1);            exp_reg("unsupported_s7", S7, 32'h0);
        exp_reg("zero_reg", ZERO, 32'h0);         exp_pc("arith_pc", 32'd64);
        run(16);
        drain();

        // Asynchronous reset between edges, then restart from address 0
        start_program(0);
        run(5);
        #2 reset = 1'b1;
        #1;
        exp_pc("async_rst_pc", 32'h0); exp_reg("async_rst_t0", T0, 32'h0);
        exp_reg("async_rst_t1", T1, 32'h0);
        drain();
        @(negedge clk);
        reset = 1'b0;
        exp_reg("restart_t0", T0, 32'h7FFFFFFF); exp_reg("restart_t1", T1, 32'h0);
        exp_pc("restart_pc", 32'd8);
        run(2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
